vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Sits directly upstream of the pixel-draw stage and drives its hcount/vcount inputs.
- Also drives the DAC/connector control signals: hsync, vsync, blank_n, sync_n and vga_clk.
- All outputs are registered and mutually aligned, so the draw stage and the DAC see the same raster position on the same clock edge.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_pix_tick.sv | 37 +++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, count type and the test-pattern colour bar table.
package vga_pkg;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Classic SMPTE-style bar order, left to right.
    localparam logic [23:0] TP_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: one pix_tick per CLK_DIV clocks plus a 50% duty pixel clock for the DAC.
module vga_pix_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pix_tick,
    output logic vga_clk
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;

    always_comb begin
        div_nxt = '0;
        if (en) div_nxt = (div == LAST) ? '0 : div + 1'b1;
    end

    // Outputs decoded from div_nxt so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
            vga_clk  <= 1'b0;
        end else begin
            div      <= div_nxt;
            pix_tick <= en && (div_nxt == LAST);
            vga_clk  <= en && (div_nxt >= HALF);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator with registered, mutually aligned outputs.
// Optional colour-bar test pattern enabled by defining VGA_TIMING_TESTPAT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output cnt_t hcount,
    output cnt_t vcount,
    output logic hsync,
    output logic vsync,
    output logic blank_n,
    output logic sync_n,
    output logic vga_clk,
    output logic pix_tick,
    output logic line_start,
    output logic frame_start
`ifdef VGA_TIMING_TESTPAT_EN
    ,
    input  logic        testpat,
    output logic [23:0] tp_rgb
`endif
);

    localparam int H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG = H_VISIBLE + H_FRONT;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VISIBLE + V_FRONT;
    localparam int VS_END = VS_BEG + V_SYNC;

    function automatic logic in_win(input cnt_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pix_tick (pix_tick),
        .vga_clk  (vga_clk)
    );

    logic adv, h_wrap, v_wrap, vis_nxt;
    cnt_t h_nxt, v_nxt;

    assign adv     = en && pix_tick;
    assign h_wrap  = adv && (hcount == cnt_t'(H_TOT - 1));
    assign v_wrap  = h_wrap && (vcount == cnt_t'(V_TOT - 1));
    assign vis_nxt = en && in_win(h_nxt, 0, H_VISIBLE) && in_win(v_nxt, 0, V_VISIBLE);

    // en low forces the origin; otherwise advance only at the end of a pix_tick cycle.
    always_comb begin
        h_nxt = hcount;
        v_nxt = vcount;
        if (!en) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : vcount + 1'b1;
        end else if (adv) begin
            h_nxt = hcount + 1'b1;
        end
    end

    // Decodes use the next-state counters so they share the counters' register edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            sync_n      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= !(en && in_win(h_nxt, HS_BEG, HS_END));
            vsync       <= !(en && in_win(v_nxt, VS_BEG, VS_END));
            blank_n     <= vis_nxt;
            sync_n      <= 1'b0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int BAR_W = H_VISIBLE / 8;

    function automatic logic [2:0] bar_idx(input cnt_t c);
        return 3'(int'(c) / BAR_W);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tp_rgb <= '0;
        else        tp_rgb <= (testpat && vis_nxt) ? TP_COLOURS[bar_idx(h_nxt)] : 24'h0;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a reduced-timing instance and a default 640x480 instance share en/rst_n.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    logic [9:0] s_h, s_v, d_h, d_v;
    logic s_hs, s_vs, s_bn, s_sn, s_vc, s_pt, s_ls, s_fs;
    logic d_hs, d_vs, d_bn, d_sn, d_vc, d_pt, d_ls, d_fs;
`ifdef VGA_TIMING_TESTPAT_EN
    logic testpat;
    logic [23:0] s_tp, d_tp;
`endif

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en), .hcount(s_h), .vcount(s_v),
        .hsync(s_hs), .vsync(s_vs), .blank_n(s_bn), .sync_n(s_sn), .vga_clk(s_vc),
        .pix_tick(s_pt), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_TESTPAT_EN
        , .testpat(testpat), .tp_rgb(s_tp)
`endif
    );

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .hcount(d_h), .vcount(d_v),
        .hsync(d_hs), .vsync(d_vs), .blank_n(d_bn), .sync_n(d_sn), .vga_clk(d_vc),
        .pix_tick(d_pt), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_TESTPAT_EN
        , .testpat(testpat), .tp_rgb(d_tp)
`endif
    );

    wire logic [27:0] obs_s = {s_h, s_v, s_hs, s_vs, s_bn, s_sn, s_vc, s_pt, s_ls, s_fs};
    wire logic [27:0] obs_d = {d_h, d_v, d_hs, d_vs, d_bn, d_sn, d_vc, d_pt, d_ls, d_fs};
    localparam logic [27:0] RST_VAL = 28'h00000C0;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic [27:0] sbq[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, o, e);
        end
    endtask

    // Position is derived from clocks elapsed since the raster was last at its idle origin.
    function automatic logic [27:0] predict(input int tt, cd, hv, hf, hsw, hb, vv, vf, vsw, vb);
        int ht, vt, d, p, h, v;
        logic hs, vs, bn, vc, pt, ls, fs;
        if (tt == 0) return RST_VAL;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        d  = tt % cd;
        p  = tt / cd;
        h  = p % ht;
        v  = (p / ht) % vt;
        pt = (d == cd - 1);
        vc = (d >= cd / 2);
        hs = !((h >= hv + hf) && (h < hv + hf + hsw));
        vs = !((v >= vv + vf) && (v < vv + vf + vsw));
        bn = (h < hv) && (v < vv);
        ls = (d == 0) && (h == 0);
        fs = ls && (v == 0);
        return {h[9:0], v[9:0], hs, vs, bn, 1'b0, vc, pt, ls, fs};
    endfunction

    task automatic cyc(input logic en_v);
        logic [27:0] es, ed;
        int tn;
        en = en_v;
        tn = en_v ? t + 1 : 0;
        sbq.push_back(predict(tn, 4, 16, 4, 6, 4, 8, 2, 2, 3));
        sbq.push_back(predict(tn, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        @(posedge clk);
        #1;
        t  = tn;
        es = sbq.pop_front();
        ed = sbq.pop_front();
        chk("sb_small", 32'(obs_s), 32'(es));
        chk("sb_def", 32'(obs_d), 32'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d observed=timeout expected=finish", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int blank_ticks, vs_low, hs_ticks, fs_cnt, n_s, n_d;
        logic found;
        blank_ticks = 0; vs_low = 0; hs_ticks = 0; fs_cnt = 0;
        rst_n = 1'b0;
        en    = 1'b0;
`ifdef VGA_TIMING_TESTPAT_EN
        testpat = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_small", 32'(obs_s), 32'(RST_VAL));
        chk("rst_def", 32'(obs_d), 32'(RST_VAL));
        rst_n = 1'b1;
        t = 0;

        // Two small frames and the first two default lines.
        for (int i = 0; i < 3600; i++) begin
            cyc(1'b1);
            if (t <= 1800) begin
                if (s_pt && s_bn) blank_ticks++;
                if (!s_vs) vs_low++;
            end
            if (t <= 1600 && d_pt && !d_hs) hs_ticks++;
            if (s_fs) fs_cnt++;
            if (t == 1600) begin
                chk("def_wrap_h", 32'(d_h), 32'd0);
                chk("def_wrap_v", 32'(d_v), 32'd1);
                chk("def_line_start", 32'(d_ls), 32'd1);
            end
            if (t == 1800) chk("small_frame_start", 32'(s_fs), 32'd1);
`ifdef VGA_TIMING_TESTPAT_EN
            if (t == 1)    chk("tp_h0", 32'(d_tp), 32'hFFFFFF);
            if (t == 320)  chk("tp_h160", 32'(d_tp), 32'h00FFFF);
            if (t == 1400) chk("tp_h700", 32'(d_tp), 32'h000000);
`endif
        end
        chk("blank_ticks", 32'(blank_ticks), 32'd128);
        chk("vsync_low_clks", 32'(vs_low), 32'd240);
        chk("hsync_low_ticks", 32'(hs_ticks), 32'd96);
        chk("frame_count", 32'(fs_cnt), 32'd2);

        // Drop en mid-frame on the small raster.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cyc(1'b1);
            if (s_h == 10'd12 && s_v == 10'd5) found = 1'b1;
        end
        chk("reach_12_5", 32'(found), 32'd1);
        cyc(1'b0);
        chk("en_off_h", 32'(s_h), 32'd0);
        chk("en_off_v", 32'(s_v), 32'd0);
        chk("en_off_blank", 32'(s_bn), 32'd0);
        chk("en_off_fs", 32'(s_fs), 32'd0);
        cyc(1'b0);
        cyc(1'b0);
        n_s = 0; n_d = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1);
            if (n_s == 0 && s_h == 10'd1) n_s = i;
            if (n_d == 0 && d_h == 10'd1) n_d = i;
        end
        chk("restart_small", 32'(n_s), 32'd4);
        chk("restart_def", 32'(n_d), 32'd2);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 50; i++) cyc(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_small", 32'(obs_s), 32'(RST_VAL));
        chk("arst_def", 32'(obs_d), 32'(RST_VAL));
        t = 0;
        @(posedge clk);
        #1;
        chk("arst_hold_small", 32'(obs_s), 32'(RST_VAL));
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cyc(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
